// File: rtl/rr_grant_scheduler.sv
// ---------------------------------------------------------------------------
// rr_grant_scheduler
//
// Round-robin owner scheduler for one shared resource. A requester wins the
// resource through a rotating-priority encoder whose pivot is one past the
// previous winner. The winner keeps a registered one-hot grant until it
// releases, drops its request, or holds for MAX_HOLD cycles. When a grant
// ends, the next winner is chosen in that same cycle, so back-to-back grants
// have no idle bubble. Because the pivot rotates, every active requester is
// served within WIDTH grants.
//
// Parameters
//   WIDTH     number of requesters (2..32, any value, not only powers of 2)
//   MAX_HOLD  longest one grant may last in cycles; 0 = unlimited
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_req          per-requester request level
//   i_release      current owner is done (ignored while idle)
//   o_grant        registered one-hot grant, all-zero when idle
//   o_grant_idx    index of the current owner, 0 when idle
//   o_grant_valid  a grant is active
//   o_preempt      one-cycle pulse: the previous grant ended only by hold expiry
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// masked_priority_encoder
//
// Rotating-priority encoder with the LSB as index 0. It returns the lowest
// set index at or above i_pivot. If there is none, it wraps around and
// returns the lowest set index overall.
//
// Ports
//   i_req    request vector
//   i_pivot  first index that gets priority
//   o_idx    winning index (0 when o_valid=0)
//   o_valid  at least one request bit is set
// ---------------------------------------------------------------------------
module masked_priority_encoder #(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_req,
    input  logic [IDX_W-1:0] i_pivot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic             hi_found;
    logic [IDX_W-1:0] hi_idx;
    logic             lo_found;
    logic [IDX_W-1:0] lo_idx;

    // NOTE: combinational logic uses blocking '=' so that later statements
    // see the values assigned earlier in the same pass. Every output also gets
    // a default at the top, which keeps any path from leaving it unassigned and
    // inferring a latch.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        // Walk from the top down so that the last hit is the lowest index.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(i);
                if (i >= int'(i_pivot)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        o_valid = lo_found;
        o_idx   = hi_found ? hi_idx : lo_idx;
    end

endmodule

module rr_grant_scheduler #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [WIDTH-1:0]         i_req,
    input  logic                     i_release,
    output logic [WIDTH-1:0]         o_grant,
    output logic [$clog2(WIDTH)-1:0] o_grant_idx,
    output logic                     o_grant_valid,
    output logic                     o_preempt
);

    localparam int IDX_W = $clog2(WIDTH);
    // With MAX_HOLD=0, $clog2(1)=0, so the counter width is held at 1 bit.
    localparam int CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             preempt_q, preempt_d;

    logic [IDX_W-1:0] pivot_base;
    logic [IDX_W-1:0] pivot;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_valid;
    logic             owner_req;
    logic             hold_expire;
    logic             grant_end;

    // While a grant is active, the only time the encoder result is used is
    // the end cycle. In that cycle the pointer is about to become the current
    // owner, so the pivot is based on the owner directly. While idle, it is
    // based on the stored last winner.
    always_comb begin
        pivot_base = (state_q == ST_GRANT) ? grant_idx_q : last_q;
        // Wrap explicitly, because WIDTH need not be a power of two.
        pivot      = (pivot_base == LAST_IDX) ? '0 : pivot_base + IDX_W'(1);
    end

    masked_priority_encoder #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_enc (
        .i_req   (i_req),
        .i_pivot (pivot),
        .o_idx   (enc_idx),
        .o_valid (enc_valid)
    );

    always_comb begin
        owner_req   = i_req[grant_idx_q];
        hold_expire = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
        grant_end   = (state_q == ST_GRANT) && (i_release || !owner_req || hold_expire);
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        preempt_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    state_d     = ST_GRANT;
                    grant_d     = WIDTH'(1) << enc_idx;
                    grant_idx_d = enc_idx;
                    cnt_d       = '0;
                end
            end

            ST_GRANT: begin
                if (grant_end) begin
                    last_d    = grant_idx_q;
                    // Report a preemption only when hold expiry alone ended
                    // the grant. A release or a dropped request in the same
                    // cycle means the owner was finished anyway.
                    preempt_d = hold_expire && !i_release && owner_req;
                    cnt_d     = '0;
                    if (enc_valid) begin
                        grant_d     = WIDTH'(1) << enc_idx;
                        grant_idx_d = enc_idx;
                    end else begin
                        state_d     = ST_IDLE;
                        grant_d     = '0;
                        grant_idx_d = '0;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    // Saturate instead of wrapping. This only matters when
                    // MAX_HOLD=0, where nothing ever clears the counter.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking '<=' so that every flop samples
    // the values from before the clock edge, whatever order they are written in.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            last_q      <= LAST_IDX;
            cnt_q       <= '0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            preempt_q   <= preempt_d;
        end
    end

    assign o_grant       = grant_q;
    assign o_grant_idx   = grant_idx_q;
    assign o_grant_valid = (state_q == ST_GRANT);
    assign o_preempt     = preempt_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// ---------------------------------------------------------------------------
// Directed bench for rr_grant_scheduler.
// dut_a uses MAX_HOLD=16 and covers release-driven rotation, a dropped
// request, and reset.
// dut_b uses MAX_HOLD=4 and covers hold-limit preemption.
// Both instances share the clock and the reset.
// ---------------------------------------------------------------------------
module tb_rr_grant_scheduler;

    logic       clk;
    logic       rst_n;

    logic [3:0] req_a;
    logic       rel_a;
    logic [3:0] grant_a;
    logic [1:0] idx_a;
    logic       valid_a;
    logic       pre_a;

    logic [3:0] req_b;
    logic       rel_b;
    logic [3:0] grant_b;
    logic [1:0] idx_b;
    logic       valid_b;
    logic       pre_b;

    int checks = 0;
    int errors = 0;

    rr_grant_scheduler #(.WIDTH(4), .MAX_HOLD(16)) dut_a (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req         (req_a),
        .i_release     (rel_a),
        .o_grant       (grant_a),
        .o_grant_idx   (idx_a),
        .o_grant_valid (valid_a),
        .o_preempt     (pre_a)
    );

    rr_grant_scheduler #(.WIDTH(4), .MAX_HOLD(4)) dut_b (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req         (req_b),
        .i_release     (rel_b),
        .o_grant       (grant_b),
        .o_grant_idx   (idx_b),
        .o_grant_valid (valid_b),
        .o_preempt     (pre_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic exp_a(input string tag, input logic [3:0] g, input logic [1:0] idx,
                         input logic v, input logic p);
        check({tag, "_a_grant"},   32'(grant_a), 32'(g));
        check({tag, "_a_idx"},     32'(idx_a),   32'(idx));
        check({tag, "_a_valid"},   32'(valid_a), 32'(v));
        check({tag, "_a_preempt"}, 32'(pre_a),   32'(p));
    endtask

    task automatic exp_b(input string tag, input logic [3:0] g, input logic [1:0] idx,
                         input logic v, input logic p);
        check({tag, "_b_grant"},   32'(grant_b), 32'(g));
        check({tag, "_b_idx"},     32'(idx_b),   32'(idx));
        check({tag, "_b_valid"},   32'(valid_b), 32'(v));
        check({tag, "_b_preempt"}, 32'(pre_b),   32'(p));
    endtask

    // Step past the next rising edge, then let outputs settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req_a = '0;
        rel_a = 1'b0;
        req_b = '0;
        rel_b = 1'b0;

        // Reset state
        #12;
        exp_a("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        exp_b("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // A single requester is granted one cycle later and held
        req_a = 4'b0100;
        tick();
        exp_a("single_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_a("single_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        end

        // Owner 2 drops its request with nobody else waiting: go idle
        req_a = 4'b0000;
        tick();
        exp_a("drop_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        rel_a = 1'b1;
        tick();
        exp_a("release_in_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        rel_a = 1'b0;

        // Fresh reset, then all request and owners release every 3 cycles
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        req_a = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_a("rot_first", 4'(1 << (k % 4)), 2'(k % 4), 1'b1, 1'b0);
            tick();
            exp_a("rot_hold1", 4'(1 << (k % 4)), 2'(k % 4), 1'b1, 1'b0);
            tick();
            exp_a("rot_hold2", 4'(1 << (k % 4)), 2'(k % 4), 1'b1, 1'b0);
            rel_a = 1'b1;
            tick();
            rel_a = 1'b0;
        end
        exp_a("rot_owner1", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Owner 1 releases while requester 2 is absent: 3 wins, then 0
        req_a = 4'b1011;
        rel_a = 1'b1;
        tick();
        exp_a("skip_to_3", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick();
        exp_a("wrap_to_0", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        rel_a = 1'b0;
        exp_a("then_1", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Asynchronous reset in the middle of owner 1's grant
        #2;
        rst_n = 1'b0;
        #1;
        exp_a("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        req_a = 4'b1111;
        #1;
        rst_n = 1'b1;
        tick();
        exp_a("after_reset", 4'b0001, 2'd0, 1'b1, 1'b0);
        req_a = 4'b0000;
        tick();
        exp_a("a_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // MAX_HOLD=4 with two requesters: each keeps the grant for 4 cycles
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        req_b = 4'b0011;
        tick();
        exp_b("hold_g0", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_b("hold_g0_keep", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        tick();
        exp_b("preempt_to_1", 4'b0010, 2'd1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_b("hold_g1_keep", 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        tick();
        exp_b("preempt_to_0", 4'b0001, 2'd0, 1'b1, 1'b1);

        // A sole requester is re-granted back-to-back on every expiry
        req_b = 4'b0001;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                exp_b("sole_keep", 4'b0001, 2'd0, 1'b1, 1'b0);
            end
            tick();
            exp_b("sole_regrant", 4'b0001, 2'd0, 1'b1, 1'b1);
        end

        // A release in the expiry cycle suppresses the preempt pulse
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_b("rel_keep", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        rel_b = 1'b1;
        tick();
        rel_b = 1'b0;
        exp_b("rel_at_expiry", 4'b0001, 2'd0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
Sequential round-robin scheduler that shares one resource among WIDTH requesters. It instantiates masked_priority_encoder (LSB=0), driving i_pivot from a registered "last winner + 1" pointer. It issues a registered one-hot grant and holds it until the owner releases, drops its request, or a hold limit expires. It then rotates the pointer so every active requester is served within WIDTH grants.

Parameters:
WIDTH, 4, number of requesters; legal range 2..32, need not be a power of 2
MAX_HOLD, 16, maximum cycles one grant may be held; 0 = unlimited; legal range 0..65535

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_req  input  WIDTH  per-requester request level
i_release  input  1  current owner finished; sampled only while o_grant_valid=1
o_grant  output  WIDTH  one-hot grant, registered; all-zero when idle
o_grant_idx  output  $clog2(WIDTH)  index of current owner; 0 when idle
o_grant_valid  output  1  a grant is active
o_preempt  output  1  one-cycle pulse: current grant ended by MAX_HOLD expiry

Behaviour:
- Reset (async assert, sync release): o_grant=0, o_grant_idx=0, o_grant_valid=0, o_preempt=0. Last-winner pointer r_last=WIDTH-1, so pivot=0 and requester 0 wins first. Hold counter=0. FSM=IDLE.
- Pivot: (r_last==WIDTH-1) ? 0 : r_last+1, computed explicitly with no reliance on power-of-2 wrap.
- Encoder priority: lowest set index >= pivot, else lowest set index < pivot.
- FSM IDLE:
  - if |i_req, the encoder winner W is registered.
  - Next cycle: o_grant=1<<W, o_grant_idx=W, o_grant_valid=1; FSM=GRANT; counter=0.
  - Latency is 1 cycle from request to grant.
- FSM GRANT: grant held stable. The grant ends on the first cycle where any of the following is true:
  (a) i_release=1
  (b) i_req[o_grant_idx]=0
  (c) MAX_HOLD!=0 and counter==MAX_HOLD-1
- On the end cycle:
  - r_last<=o_grant_idx.
  - The encoder is re-evaluated in that same cycle with pivot=o_grant_idx+1 (wrapped) and the current i_req.
  - If a winner exists, the new grant appears on the next cycle with no idle bubble. FSM stays GRANT; counter=0.
  - Otherwise all grant outputs go to 0 next cycle; FSM=IDLE.
- The ending owner may be re-granted back-to-back only if it is the sole requester. Its i_req is still high under (a)/(c); under (b) it is not.
- o_preempt=1 for exactly one cycle (the cycle after the end), only when (c) ended the grant and neither (a) nor (b) was also true.
- Otherwise the counter increments by 1 per GRANT cycle. Its width is $clog2(MAX_HOLD+1), minimum 1, and it never wraps.
- i_release while IDLE is ignored.
- Requests arriving mid-grant never disturb the current grant.
- o_grant is always one-hot or zero, and consistent with o_grant_idx/o_grant_valid every cycle.
- Reset mid-grant: all outputs clear immediately (async) and r_last returns to WIDTH-1.

Test Plan:
- Reset, then i_req=4'b0100 held → cycle+1: o_grant=4'b0100, o_grant_idx=2, o_grant_valid=1; no change until release.
- i_req=4'b1111 held, i_release pulsed 1 cycle every 3 cycles → grants in order 0,1,2,3,0. Each new grant appears the cycle after the release, with no bubble.
- Owner 1 granted, i_req=4'b1011, i_release → next grant is 3 (pivot 2, index 2 not requesting). Repeat → 0.
- MAX_HOLD=4, i_req=4'b0011, no release → grant 0 held exactly 4 cycles, o_preempt pulses once, then grant 1 for 4 cycles, then 0.
- MAX_HOLD=4, i_req=4'b0001 only → grant 0 re-issued back-to-back every 4 cycles; o_preempt pulses each time; o_grant_valid never drops.
- Owner 2 drops i_req with no other requests → next cycle all outputs 0, FSM IDLE. Then assert i_rst_n=0 during a later grant → outputs 0 asynchronously. After reset, i_req=4'b1111 → grant 0.
